// File: rtl/ex_operand_stage.sv
// ex_operand_stage: decode->execute pipeline register with operand formation.
// Latches the decoded instruction, its PC and the register-file read data.
// From the latched values it builds the immediate, applies MEM/WB forwarding
// and selects ALU operands A and B.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  decode handshake (in_ready = !stall)
//   in_inst, in_pc, in_rs1/2_data      decoded instruction payload
//   stall, flush                       hazard hold / redirect kill
//   fwd_{mem,wb}_{wen,rd,data}         forwarding sources
//   out_valid, out_inst, out_pc        registered instruction state
//   out_imm, out_rs1/2, out_op_a/b     operands formed from the registers
module ex_operand_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        fwd_mem_wen,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_wen,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  logic            valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [6:0]      opcode;

  assign rs1_idx  = inst_q[19:15];
  assign rs2_idx  = inst_q[24:20];
  assign opcode   = inst_q[6:0];
  assign in_ready = !stall;

  // MEM result wins over WB; x0 never forwards and always reads zero.
  always_comb begin
    rs1_fwd = rs1_q;
    rs2_fwd = rs2_q;
    if (FWD_EN) begin
      if (rs1_idx == 5'd0)                                rs1_fwd = '0;
      else if (fwd_mem_wen && fwd_mem_rd == rs1_idx)      rs1_fwd = fwd_mem_data;
      else if (fwd_wb_wen && fwd_wb_rd == rs1_idx)        rs1_fwd = fwd_wb_data;
      if (rs2_idx == 5'd0)                                rs2_fwd = '0;
      else if (fwd_mem_wen && fwd_mem_rd == rs2_idx)      rs2_fwd = fwd_mem_data;
      else if (fwd_wb_wen && fwd_wb_rd == rs2_idx)        rs2_fwd = fwd_wb_data;
    end
  end

  // Immediate decode by opcode.
  always_comb begin
    imm = '0;
    case (opcode)
      OP_ARI_I, OP_LOAD, OP_JALR:
        imm = {{20{inst_q[31]}}, inst_q[31:20]};
      OP_STORE:
        imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      OP_BRANCH:
        imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst_q[31:12], 12'b0};
      OP_JAL:
        imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      OP_CSR:
        imm = {27'b0, inst_q[19:15]};
      default:
        imm = '0;
    endcase
  end

  // ALU operand selection.
  always_comb begin
    out_op_a = rs1_fwd;
    out_op_b = rs2_fwd;
    case (opcode)
      OP_AUIPC, OP_JAL, OP_BRANCH: out_op_a = pc_q;
      OP_LUI:                      out_op_a = '0;
      default:                     out_op_a = rs1_fwd;
    endcase
    case (opcode)
      OP_ARI_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_STORE, OP_LOAD, OP_CSR: out_op_b = imm;
      default:                              out_op_b = rs2_fwd;
    endcase
  end

  // Pipeline register: flush > stall > capture > bubble.
  // During a stall the operand regs absorb forwarded values so a producer
  // that retires past WB while we wait is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= RESET_PC;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (stall) begin
      rs1_q   <= rs1_fwd;
      rs2_q   <= rs2_fwd;
    end else if (in_valid) begin
      valid_q <= 1'b1;
      inst_q  <= in_inst;
      pc_q    <= in_pc;
      rs1_q   <= in_rs1_data;
      rs2_q   <= in_rs2_data;
    end else begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
  assign out_imm   = imm;
  assign out_rs1   = rs1_fwd;
  assign out_rs2   = rs2_fwd;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Decode→execute pipeline register plus operand formation for the ALU.
- Captures the decoded instruction, PC and register-file read data, then generates the immediate.
- Applies MEM/WB forwarding and drives ALU operand A (rs1/PC/zero) and operand B (rs2/imm).
- Sits directly upstream of the ALU. Consumes the stage-3 instruction that the A/B select logic decodes.

Parameters:
- RESET_PC, 32'h0000_0000, value of out_pc after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded on reset and flush.
- FWD_EN, 1, 1 = forwarding enabled; 0 = register-file data used unmodified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  stage accepts; equals !stall
- in_inst  input  32  decoded instruction
- in_pc  input  32  instruction PC
- in_rs1_data  input  32  register-file read port 1
- in_rs2_data  input  32  register-file read port 2
- stall  input  1  hazard unit hold request
- flush  input  1  branch/jump redirect kill
- fwd_mem_wen  input  1  MEM stage writes rd
- fwd_mem_rd  input  5  MEM stage rd
- fwd_mem_data  input  32  MEM stage result
- fwd_wb_wen  input  1  WB stage writes rd
- fwd_wb_rd  input  5  WB stage rd
- fwd_wb_data  input  32  WB stage result
- out_valid  output  1  registered instruction is live
- out_inst  output  32  registered instruction
- out_pc  output  32  registered PC
- out_imm  output  32  generated immediate
- out_rs1  output  32  forwarded rs1 value (branch compare, JALR)
- out_rs2  output  32  forwarded rs2 value (store data, branch compare)
- out_op_a  output  32  ALU operand A
- out_op_b  output  32  ALU operand B

Behaviour:
- Reset (async, rst_n=0) forces the following regardless of clk:
  - out_valid=0, inst reg=NOP_INST, pc reg=RESET_PC, rs1/rs2 regs=0.
  - Combinational outputs then follow from those registers: out_imm=0, out_op_a=0, out_op_b=0.
- Register update on each rising edge, in priority order:
  1. flush: valid←0, inst←NOP_INST, pc and data regs unchanged.
  2. stall: hold inst/pc/valid; rs1/rs2 regs refresh with the forwarded value (see below).
  3. in_valid: capture all inputs, valid←1.
  4. Otherwise: valid←0, inst←NOP_INST.
- Latency: 1 cycle, in→out.
- Handshake: transfer occurs iff in_valid && in_ready. in_ready is combinational from stall only.
- Forwarding (combinational, per source operand; rs1=inst[19:15], rs2=inst[24:20]):
  - Take fwd_mem_data if fwd_mem_wen, rd≠0 and rd matches the source.
  - Else take fwd_wb_data under the same conditions.
  - Else take the register value.
  - MEM beats WB when both match. Source x0 always yields 0.
- Stall refresh: while stalled, each held rs reg is rewritten with its forwarded value every cycle. A producer draining past WB during the stall is therefore not lost.
- Immediate, by opcode:
  - I-type (ARI_ITYPE, LOAD, JALR): sext inst[31:20].
  - S: sext {inst[31:25],inst[11:7]}.
  - B: sext {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U (LUI, AUIPC): {inst[31:12],12'b0}.
  - J: sext {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - CSR: zext inst[19:15].
  - Other opcodes: 0.
- Operand A:
  - PC for AUIPC, JAL, BRANCH.
  - 0 for LUI.
  - out_rs1 for all other opcodes.
- Operand B:
  - out_imm for ARI_ITYPE, LUI, AUIPC, JAL, JALR, BRANCH, STORE, LOAD, CSR.
  - out_rs2 for all other opcodes.
- Widths: all arithmetic is 32-bit; sign extension is from the instruction sign bit, inst[31].
- FWD_EN=0: out_rs1/out_rs2 equal the regs unconditionally; the stall refresh becomes a plain hold.

Test Plan:
- Reset, then release: out_valid=0, out_inst=32'h00000013, out_pc=0; pulse rst_n low mid-stream → all clear without a clock edge.
- in_inst=addi x5,x1,-4 (32'hFFC08293), in_rs1_data=10, no hazards → next cycle out_imm=32'hFFFFFFFC, op_a=10, op_b=32'hFFFFFFFC, out_valid=1.
- add x3,x1,x2 with fwd_mem_rd=1 (data 7) and fwd_wb_rd=1 (data 9), both wen → out_rs1=7. Same case with rd=0 → register value used.
- sw x2,8(x1): out_imm=8, op_b=8, out_rs2=forwarded x2. jal at pc 0x100 with offset 0x20 → op_a=0x100, op_b=0x20.
- Stall for 3 cycles, WB producing x1=0x55 only in stall cycle 1 → after stall release out_rs1=0x55; in_ready=0 throughout the stall.
- flush and stall and in_valid all high on one edge → out_valid=0, out_inst=NOP; next clean cycle accepts the new instruction.
